// File: rtl/em_seek_driver_if.sv
// AXI4-Stream bundle used for the read loader input and the end-of-read record output.
interface axi4_stream_if #(
  parameter int W = 8
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/em_seek_driver.sv
// Per-read control stage ahead of the bidirectional EM seeker:
// loads a read, walks it with repeated seek calls, posts an end-of-read record.
package em_seek_pkg;
  typedef enum logic [2:0] {
    sym_a = 3'd0,
    sym_c = 3'd1,
    sym_g = 3'd2,
    sym_t = 3'd3,
    sym_n = 3'd4
  } symbol_t;
endpackage

module em_seek_driver
  import em_seek_pkg::*;
#(
  parameter int GD_READ_LEN = 78,
  parameter int ID_W        = 16,
  parameter int CNT_W       = 8,
  parameter int POS_W       = $clog2(GD_READ_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axi4_stream_if.slave              s_axis_read,
  output symbol_t [0:GD_READ_LEN-1] gd_read,
  output logic [POS_W-1:0]          pos_in,
  output logic                      start,
  input  logic [POS_W-1:0]          pos_out,
  input  logic                      finish,
  input  logic                      busy,
  axi4_stream_if.master             m_axis_rdone,
  output logic                      drv_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_ADV,
    S_DONE
  } state_t;

  state_t            state;
  logic [POS_W-1:0]  len;
  logic [POS_W-1:0]  pos;
  logic [POS_W-1:0]  nxt;
  logic [CNT_W-1:0]  seeks;
  logic [ID_W-1:0]   read_id;
  logic              overflow;
  logic              ld_ready;
  logic              rd_valid;

  logic              beat;
  logic              full;
  logic [POS_W-1:0]  len_nx;
  logic [POS_W:0]    pos_inc;
  logic [POS_W:0]    next_pos;

  assign beat    = s_axis_read.tvalid & ld_ready;
  assign full    = (len == POS_W'(GD_READ_LEN));
  assign len_nx  = full ? len : len + POS_W'(1);

  // One extra bit so pos+1 cannot wrap before the length compare.
  assign pos_inc  = {1'b0, pos} + (POS_W+1)'(1);
  assign next_pos = (nxt > pos) ? {1'b0, nxt} : pos_inc;

  assign s_axis_read.tready = ld_ready;
  assign m_axis_rdone.tvalid = rd_valid;
  assign m_axis_rdone.tlast  = 1'b1;
  assign m_axis_rdone.tdata  = {overflow, seeks, len, read_id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      start    <= 1'b0;
      pos_in   <= '0;
      drv_busy <= 1'b0;
      ld_ready <= 1'b0;
      rd_valid <= 1'b0;
      len      <= '0;
      pos      <= '0;
      nxt      <= '0;
      seeks    <= '0;
      overflow <= 1'b0;
      read_id  <= '0;
      for (int i = 0; i < GD_READ_LEN; i++) begin
        gd_read[i] <= sym_n;
      end
    end else begin
      start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!busy) begin
            for (int i = 0; i < GD_READ_LEN; i++) begin
              gd_read[i] <= sym_n;
            end
            len      <= '0;
            seeks    <= '0;
            overflow <= 1'b0;
            ld_ready <= 1'b1;
            drv_busy <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (beat) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              gd_read[len] <= symbol_t'(s_axis_read.tdata);
            end
            len <= len_nx;
            if (s_axis_read.tlast) begin
              ld_ready <= 1'b0;
              pos      <= '0;
              if (len_nx == '0) begin
                rd_valid <= 1'b1;
                state    <= S_DONE;
              end else begin
                start  <= 1'b1;
                pos_in <= '0;
                state  <= S_START;
              end
            end
          end
        end
        S_START: begin
          if (seeks != '1) begin
            seeks <= seeks + CNT_W'(1);
          end
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (finish) begin
            nxt   <= pos_out;
            state <= S_ADV;
          end
        end
        S_ADV: begin
          pos <= next_pos[POS_W-1:0];
          if (next_pos < {1'b0, len}) begin
            start  <= 1'b1;
            pos_in <= next_pos[POS_W-1:0];
            state  <= S_START;
          end else begin
            rd_valid <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (m_axis_rdone.tready) begin
            rd_valid <= 1'b0;
            drv_busy <= 1'b0;
            read_id  <= read_id + ID_W'(1);
            state    <= S_IDLE;
          end
        end
        default: begin
          ld_ready <= 1'b0;
          rd_valid <= 1'b0;
          drv_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
